// File: rtl/pkt_sender_pkg.sv
// Shared types and constants for the multi-beat TCP transmit sender.
package pkt_sender_pkg;

  localparam int STATUS_ERR_BIT_DEF = 62;
  localparam int LEN_LSB = 16;
  localparam int LEN_W   = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DROP = 2'd2
  } egress_state_e;

  typedef enum logic {
    NORMAL  = 1'b0,
    DISCARD = 1'b1
  } ingress_mode_e;

  // Metadata word: byte length in the upper half, session in the lower half.
  function automatic logic [31:0] pack_meta(input logic [LEN_W-1:0] len,
                                            input logic [LEN_LSB-1:0] session);
    logic [31:0] word;
    word = '0;
    word[LEN_LSB +: LEN_W] = len;
    word[LEN_LSB-1:0]      = session;
    return word;
  endfunction

endpackage

// File: rtl/nukv_fifogen.sv
// First-word-fall-through FIFO: array storage with a registered read into an output stage.
module nukv_fifogen #(
  parameter int DATA_SIZE = 32,
  parameter int ADDR_BITS = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_SIZE-1:0] s_axis_TDATA,
  input  logic                 s_axis_TVALID,
  output logic                 s_axis_TREADY,
  output logic [DATA_SIZE-1:0] m_axis_TDATA,
  output logic                 m_axis_TVALID,
  input  logic                 m_axis_TREADY
);

  localparam int DEPTH = 1 << ADDR_BITS;
  localparam logic [ADDR_BITS:0]   FULL_COUNT = {1'b1, {ADDR_BITS{1'b0}}};
  localparam logic [ADDR_BITS:0]   COUNT_ONE  = 1;
  localparam logic [ADDR_BITS-1:0] PTR_ONE    = 1;

  logic [DATA_SIZE-1:0] mem [DEPTH];
  logic [ADDR_BITS-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [ADDR_BITS:0]   count_reg, count_next;
  logic                 out_valid_reg;
  logic [DATA_SIZE-1:0] out_data_reg;
  logic                 push, pop_out, load;

  assign s_axis_TREADY = (count_reg != FULL_COUNT);
  assign m_axis_TVALID = out_valid_reg;
  assign m_axis_TDATA  = out_data_reg;

  assign push    = s_axis_TVALID & s_axis_TREADY;
  assign pop_out = out_valid_reg & m_axis_TREADY;
  // Refill the output stage whenever it is empty or being drained this cycle.
  assign load    = (count_reg != '0) & (~out_valid_reg | pop_out);

  always_comb begin
    count_next = count_reg;
    case ({push, load})
      2'b10:   count_next = count_reg + COUNT_ONE;
      2'b01:   count_next = count_reg - COUNT_ONE;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      if (load) rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      count_reg <= count_next;
      if (load)
        out_valid_reg <= 1'b1;
      else if (pop_out)
        out_valid_reg <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= s_axis_TDATA;
    if (load) out_data_reg <= mem[rd_ptr_reg];
  end

endmodule

// File: rtl/pkt_sender_mb_keep_popcount.sv
// Counts set byte enables of a beat; enables are contiguous so this is the byte count.
module keep_popcount #(
  parameter int KEEP_WIDTH = 64,
  parameter int CNT_W      = $clog2(KEEP_WIDTH) + 1
) (
  input  logic [KEEP_WIDTH-1:0] keep,
  output logic [CNT_W-1:0]      count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < KEEP_WIDTH; i++)
      count = count + CNT_W'(keep[i]);
  end

endmodule

// File: rtl/pkt_sender_mb.sv
// Multi-beat TCP transmit sender: buffers whole packets, issues tx metadata on the
// closing beat, then forwards or discards each packet according to its tx status.
module pkt_sender_mb
  import pkt_sender_pkg::*;
#(
  parameter int DATA_WIDTH        = 512,
  parameter int KEEP_WIDTH        = DATA_WIDTH / 8,
  parameter int SESSION_WIDTH     = 16,
  parameter int MAX_PKT_BEATS     = 16,
  parameter int PAYLOAD_ADDR_BITS = 5,
  parameter int META_ADDR_BITS    = 4,
  parameter int STATUS_ERR_BIT    = STATUS_ERR_BIT_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [DATA_WIDTH-1:0]    s_axis_pkt_TDATA,
  input  logic [KEEP_WIDTH-1:0]    s_axis_pkt_TKEEP,
  input  logic                     s_axis_pkt_TLAST,
  input  logic [SESSION_WIDTH-1:0] s_axis_pkt_TUSER,
  input  logic                     s_axis_pkt_TVALID,
  output logic                     s_axis_pkt_TREADY,
  input  logic [63:0]              s_axis_tx_status_TDATA,
  input  logic                     s_axis_tx_status_TVALID,
  output logic                     s_axis_tx_status_TREADY,
  output logic [31:0]              m_axis_tx_metadata_TDATA,
  output logic                     m_axis_tx_metadata_TVALID,
  input  logic                     m_axis_tx_metadata_TREADY,
  output logic [DATA_WIDTH-1:0]    m_axis_tx_data_TDATA,
  output logic [KEEP_WIDTH-1:0]    m_axis_tx_data_TKEEP,
  output logic                     m_axis_tx_data_TLAST,
  output logic                     m_axis_tx_data_TVALID,
  input  logic                     m_axis_tx_data_TREADY,
  output logic [31:0]              sent_cnt,
  output logic [31:0]              drop_cnt,
  output logic [31:0]              oversize_cnt
);

  localparam int PAY_W  = DATA_WIDTH + KEEP_WIDTH + 1;
  localparam int BIDX_W = (MAX_PKT_BEATS > 1) ? $clog2(MAX_PKT_BEATS) : 1;
  localparam int CNT_W  = $clog2(KEEP_WIDTH) + 1;
  localparam logic [BIDX_W-1:0] LAST_IDX = BIDX_W'(MAX_PKT_BEATS - 1);
  localparam logic [BIDX_W-1:0] BIDX_ONE = 1;

  // ---------------- ingress ----------------
  ingress_mode_e            mode_reg;
  logic [BIDX_W-1:0]        beat_idx_reg;
  logic [SESSION_WIDTH-1:0] session_reg;
  logic [31:0]              oversize_cnt_reg;

  logic                     last_eff, accept, store, close;
  logic                     pay_in_ready, meta_in_ready;
  logic [SESSION_WIDTH-1:0] session_cur;
  logic [CNT_W-1:0]         keep_ones;
  logic [LEN_W-1:0]         pkt_len;
  logic [31:0]              meta_word;

  // A beat at the size cap closes the packet whether or not TLAST is set.
  assign last_eff    = s_axis_pkt_TLAST | (beat_idx_reg == LAST_IDX);
  assign s_axis_pkt_TREADY = rst_n & ((mode_reg == DISCARD) |
                             (pay_in_ready & (meta_in_ready | ~last_eff)));
  assign accept      = s_axis_pkt_TVALID & s_axis_pkt_TREADY;
  assign store       = accept & (mode_reg == NORMAL);
  assign close       = store & last_eff;
  assign session_cur = (beat_idx_reg == '0) ? s_axis_pkt_TUSER : session_reg;
  assign pkt_len     = LEN_W'(beat_idx_reg) * LEN_W'(KEEP_WIDTH) + LEN_W'(keep_ones);
  assign meta_word   = pack_meta(pkt_len, LEN_LSB'(session_cur));

  keep_popcount #(.KEEP_WIDTH(KEEP_WIDTH), .CNT_W(CNT_W)) u_keep_popcount (
    .keep  (s_axis_pkt_TKEEP),
    .count (keep_ones)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode_reg         <= NORMAL;
      beat_idx_reg     <= '0;
      session_reg      <= '0;
      oversize_cnt_reg <= '0;
    end else if (accept) begin
      if (mode_reg == DISCARD) begin
        if (s_axis_pkt_TLAST) mode_reg <= NORMAL;
      end else begin
        if (beat_idx_reg == '0) session_reg <= s_axis_pkt_TUSER;
        if (last_eff) begin
          beat_idx_reg <= '0;
          if (!s_axis_pkt_TLAST) begin
            mode_reg         <= DISCARD;
            oversize_cnt_reg <= oversize_cnt_reg + 32'd1;
          end
        end else begin
          beat_idx_reg <= beat_idx_reg + BIDX_ONE;
        end
      end
    end
  end

  // ---------------- FIFOs ----------------
  logic [PAY_W-1:0] pay_head;
  logic             pay_valid, pay_pop;
  logic             meta_valid;
  logic             status_in_ready, status_valid, status_err, status_pop;
  logic             unused_status;

  assign unused_status = ^s_axis_tx_status_TDATA;

  nukv_fifogen #(.DATA_SIZE(PAY_W), .ADDR_BITS(PAYLOAD_ADDR_BITS)) u_payload_fifo (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_axis_TDATA  ({last_eff, s_axis_pkt_TKEEP, s_axis_pkt_TDATA}),
    .s_axis_TVALID (store),
    .s_axis_TREADY (pay_in_ready),
    .m_axis_TDATA  (pay_head),
    .m_axis_TVALID (pay_valid),
    .m_axis_TREADY (pay_pop)
  );

  nukv_fifogen #(.DATA_SIZE(32), .ADDR_BITS(META_ADDR_BITS)) u_meta_fifo (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_axis_TDATA  (meta_word),
    .s_axis_TVALID (close),
    .s_axis_TREADY (meta_in_ready),
    .m_axis_TDATA  (m_axis_tx_metadata_TDATA),
    .m_axis_TVALID (meta_valid),
    .m_axis_TREADY (m_axis_tx_metadata_TREADY)
  );

  nukv_fifogen #(.DATA_SIZE(1), .ADDR_BITS(META_ADDR_BITS)) u_status_fifo (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_axis_TDATA  (s_axis_tx_status_TDATA[STATUS_ERR_BIT]),
    .s_axis_TVALID (s_axis_tx_status_TVALID),
    .s_axis_TREADY (status_in_ready),
    .m_axis_TDATA  (status_err),
    .m_axis_TVALID (status_valid),
    .m_axis_TREADY (status_pop)
  );

  assign s_axis_tx_status_TREADY   = rst_n & status_in_ready;
  assign m_axis_tx_metadata_TVALID = rst_n & meta_valid;

  // ---------------- egress ----------------
  egress_state_e state_reg;
  logic [31:0]   sent_cnt_reg, drop_cnt_reg;
  logic          pay_last;

  assign pay_last   = pay_head[PAY_W-1];
  assign status_pop = (state_reg == IDLE) & status_valid;

  assign m_axis_tx_data_TVALID = rst_n & (state_reg == SEND) & pay_valid;
  assign m_axis_tx_data_TDATA  = pay_head[DATA_WIDTH-1:0];
  assign m_axis_tx_data_TKEEP  = pay_head[DATA_WIDTH +: KEEP_WIDTH];
  assign m_axis_tx_data_TLAST  = m_axis_tx_data_TVALID & pay_last;
  // Dropped packets drain one beat per cycle without ever showing TVALID.
  assign pay_pop = (m_axis_tx_data_TVALID & m_axis_tx_data_TREADY) |
                   ((state_reg == DROP) & pay_valid);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      sent_cnt_reg <= '0;
      drop_cnt_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: if (status_valid) state_reg <= status_err ? DROP : SEND;
        SEND: if (pay_pop && pay_last) begin
          sent_cnt_reg <= sent_cnt_reg + 32'd1;
          state_reg    <= IDLE;
        end
        DROP: if (pay_pop && pay_last) begin
          drop_cnt_reg <= drop_cnt_reg + 32'd1;
          state_reg    <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign sent_cnt     = sent_cnt_reg;
  assign drop_cnt     = drop_cnt_reg;
  assign oversize_cnt = oversize_cnt_reg;

endmodule

// File: tb/tb_pkt_sender_mb.sv
// Directed bench for pkt_sender_mb: packets, status errors, truncation, stalls and reset.
module tb_pkt_sender_mb;

  localparam int DW = 512;
  localparam int KW = 64;
  localparam int SW = 16;

  typedef logic [KW+DW:0] beat_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] pkt_data;
  logic [KW-1:0] pkt_keep;
  logic          pkt_last;
  logic [SW-1:0] pkt_user;
  logic          pkt_valid, pkt_ready;
  logic [63:0]   st_data;
  logic          st_valid, st_ready;
  logic [31:0]   meta_data;
  logic          meta_valid, meta_ready;
  logic [DW-1:0] tx_data;
  logic [KW-1:0] tx_keep;
  logic          tx_last, tx_valid, tx_ready;
  logic [31:0]   sent_cnt, drop_cnt, oversize_cnt;

  beat_t       out_q[$];
  beat_t       exp_q[$];
  logic [31:0] meta_q[$];
  int          vectors = 0;
  int          miscompares = 0;
  logic        rand_rdy = 1'b0;
  logic [KW-1:0] ones;

  always #5 clk = ~clk;

  pkt_sender_mb dut (
    .clk                       (clk),
    .rst_n                     (rst_n),
    .s_axis_pkt_TDATA          (pkt_data),
    .s_axis_pkt_TKEEP          (pkt_keep),
    .s_axis_pkt_TLAST          (pkt_last),
    .s_axis_pkt_TUSER          (pkt_user),
    .s_axis_pkt_TVALID         (pkt_valid),
    .s_axis_pkt_TREADY         (pkt_ready),
    .s_axis_tx_status_TDATA    (st_data),
    .s_axis_tx_status_TVALID   (st_valid),
    .s_axis_tx_status_TREADY   (st_ready),
    .m_axis_tx_metadata_TDATA  (meta_data),
    .m_axis_tx_metadata_TVALID (meta_valid),
    .m_axis_tx_metadata_TREADY (meta_ready),
    .m_axis_tx_data_TDATA      (tx_data),
    .m_axis_tx_data_TKEEP      (tx_keep),
    .m_axis_tx_data_TLAST      (tx_last),
    .m_axis_tx_data_TVALID     (tx_valid),
    .m_axis_tx_data_TREADY     (tx_ready),
    .sent_cnt                  (sent_cnt),
    .drop_cnt                  (drop_cnt),
    .oversize_cnt              (oversize_cnt)
  );

  // Output monitor: collects transfers and checks hold-under-stall and TLAST/TVALID.
  beat_t prev_beat;
  logic  prev_hold = 1'b0;
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (prev_hold) begin
        vectors++;
        assert (tx_valid === 1'b1 && {tx_last, tx_keep, tx_data} === prev_beat)
          else begin
            miscompares++;
            $error("FAIL hold_stable: observed valid=%b beat=%h required held beat=%h",
                   tx_valid, {tx_last, tx_keep, tx_data}, prev_beat);
          end
      end
      if (tx_last === 1'b1) begin
        vectors++;
        assert (tx_valid === 1'b1)
          else begin
            miscompares++;
            $error("FAIL last_without_valid: observed valid=%b required 1", tx_valid);
          end
      end
      if (tx_valid === 1'b1 && tx_ready === 1'b1) out_q.push_back({tx_last, tx_keep, tx_data});
      if (meta_valid === 1'b1 && meta_ready === 1'b1) meta_q.push_back(meta_data);
      prev_hold = (tx_valid === 1'b1) && (tx_ready !== 1'b1);
      prev_beat = {tx_last, tx_keep, tx_data};
    end else begin
      prev_hold = 1'b0;
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (rand_rdy) tx_ready = ($urandom_range(0, 99) < 30);
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: observed no finish required finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
      else begin
        miscompares++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
  endtask

  task automatic chk_meta(input int i, input logic [31:0] exp);
    logic [31:0] obs;
    obs = (i < meta_q.size()) ? meta_q[i] : 32'hxxxxxxxx;
    chk($sformatf("meta[%0d]", i), {32'd0, obs}, {32'd0, exp});
  endtask

  function automatic logic [DW-1:0] beat_data(input logic [15:0] tag, input logic [15:0] b);
    return {16{tag, b}};
  endfunction

  task automatic send_beat(input logic [15:0] sess, input logic [15:0] tag, input int b,
                           input logic last, input logic [KW-1:0] keep);
    logic ok, rdy;
    ok = 1'b0;
    pkt_data  = beat_data(tag, 16'(b));
    pkt_keep  = keep;
    pkt_last  = last;
    pkt_user  = sess;
    pkt_valid = 1'b1;
    for (int c = 0; c < 3000 && !ok; c++) begin
      @(negedge clk);
      rdy = pkt_ready;
      @(posedge clk);
      #1;
      ok = rdy;
    end
    pkt_valid = 1'b0;
    chk("pkt_accept", {63'd0, ok}, 64'd1);
  endtask

  task automatic send_pkt(input logic [15:0] sess, input logic [15:0] tag, input int n,
                          input logic [KW-1:0] last_keep);
    for (int b = 0; b < n; b++)
      send_beat(sess, tag, b, b == n - 1, (b == n - 1) ? last_keep : ones);
  endtask

  task automatic send_status(input logic err);
    logic ok, rdy;
    ok = 1'b0;
    st_data = '0;
    st_data[62] = err;
    st_valid = 1'b1;
    for (int c = 0; c < 3000 && !ok; c++) begin
      @(negedge clk);
      rdy = st_ready;
      @(posedge clk);
      #1;
      ok = rdy;
    end
    st_valid = 1'b0;
    chk("status_accept", {63'd0, ok}, 64'd1);
  endtask

  // Expected forwarded beats: truncated to 16 beats, TLAST on the final kept beat.
  task automatic exp_pkt(input logic [15:0] tag, input int n, input logic [KW-1:0] last_keep);
    int m;
    m = (n > 16) ? 16 : n;
    for (int b = 0; b < m; b++)
      exp_q.push_back({(b == m - 1), (b == n - 1) ? last_keep : ones, beat_data(tag, 16'(b))});
  endtask

  task automatic wait_out();
    for (int c = 0; c < 4000 && out_q.size() < exp_q.size(); c++) @(negedge clk);
    repeat (5) @(negedge clk);
    chk("out_beats", 64'(out_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
      vectors++;
      assert (out_q[i] === exp_q[i])
        else begin
          miscompares++;
          $error("FAIL beat[%0d]: observed %h expected %h", i, out_q[i], exp_q[i]);
        end
    end
    out_q.delete();
    exp_q.delete();
    @(posedge clk);
    #1;
  endtask

  initial begin
    ones = '1;
    rst_n = 1'b0;
    pkt_data = '0; pkt_keep = '0; pkt_last = 1'b0; pkt_user = '0; pkt_valid = 1'b0;
    st_data = '0; st_valid = 1'b0;
    tx_ready = 1'b1; meta_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_pkt_tready", {63'd0, pkt_ready}, 64'd0);
    chk("rst_status_tready", {63'd0, st_ready}, 64'd0);
    chk("rst_meta_tvalid", {63'd0, meta_valid}, 64'd0);
    chk("rst_tx_tvalid", {63'd0, tx_valid}, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_sent", {32'd0, sent_cnt}, 64'd0);
    chk("rst_drop", {32'd0, drop_cnt}, 64'd0);
    chk("rst_oversize", {32'd0, oversize_cnt}, 64'd0);
    @(posedge clk); #1;

    // Single 1-beat packet
    send_pkt(16'h0005, 16'h0101, 1, ones);
    send_status(1'b0);
    exp_pkt(16'h0101, 1, ones);
    wait_out();
    chk("t1_meta_n", 64'(meta_q.size()), 64'd1);
    chk_meta(0, 32'h0040_0005);
    chk("t1_sent", {32'd0, sent_cnt}, 64'd1);
    meta_q.delete();

    // 3-beat packet with 8-byte tail
    send_pkt(16'h0012, 16'h0202, 3, 64'h0000_0000_0000_00FF);
    send_status(1'b0);
    exp_pkt(16'h0202, 3, 64'h0000_0000_0000_00FF);
    wait_out();
    chk_meta(0, 32'h0088_0012);
    chk("t2_sent", {32'd0, sent_cnt}, 64'd2);
    meta_q.delete();

    // Status error on the middle of three packets
    for (int i = 0; i < 3; i++) send_pkt(16'h0021 + 16'(i), 16'h0301 + 16'(i), 2, ones);
    send_status(1'b0);
    send_status(1'b1);
    send_status(1'b0);
    exp_pkt(16'h0301, 2, ones);
    exp_pkt(16'h0303, 2, ones);
    wait_out();
    chk("t3_meta_n", 64'(meta_q.size()), 64'd3);
    for (int i = 0; i < 3; i++) chk_meta(i, 32'h0080_0021 + 32'(i));
    chk("t3_sent", {32'd0, sent_cnt}, 64'd4);
    chk("t3_drop", {32'd0, drop_cnt}, 64'd1);
    meta_q.delete();

    // Oversize 20-beat packet truncated to 16, followed by a normal packet
    send_pkt(16'h0030, 16'h0400, 20, ones);
    send_pkt(16'h0031, 16'h0401, 1, 64'h0000_0000_0000_000F);
    send_status(1'b0);
    send_status(1'b0);
    exp_pkt(16'h0400, 20, ones);
    exp_pkt(16'h0401, 1, 64'h0000_0000_0000_000F);
    wait_out();
    chk("t4_meta_n", 64'(meta_q.size()), 64'd2);
    chk_meta(0, 32'h0400_0030);
    chk_meta(1, 32'h0004_0031);
    chk("t4_oversize", {32'd0, oversize_cnt}, 64'd1);
    chk("t4_sent", {32'd0, sent_cnt}, 64'd6);
    meta_q.delete();

    // Random egress backpressure, metadata stalled, payload FIFO filled to capacity
    rand_rdy = 1'b1;
    meta_ready = 1'b0;
    for (int i = 0; i < 8; i++) send_pkt(16'h0040 + 16'(i), 16'h0500 + 16'(i), 4, ones);
    send_beat(16'h0048, 16'h0508, 0, 1'b0, ones);
    pkt_data = beat_data(16'h0508, 16'd1); pkt_keep = ones; pkt_last = 1'b0; pkt_valid = 1'b1;
    repeat (3) @(negedge clk);
    chk("t5_pkt_tready_full", {63'd0, pkt_ready}, 64'd0);
    chk("t5_meta_stalled", 64'(meta_q.size()), 64'd0);
    @(posedge clk); #1;
    pkt_valid = 1'b0;
    repeat (25) @(posedge clk);
    #1;
    meta_ready = 1'b1;
    for (int i = 0; i < 9; i++) send_status(1'b0);
    for (int b = 1; b < 4; b++) send_beat(16'h0048, 16'h0508, b, b == 3, ones);
    for (int i = 0; i < 9; i++) exp_pkt(16'h0500 + 16'(i), 4, ones);
    wait_out();
    chk("t5_meta_n", 64'(meta_q.size()), 64'd9);
    for (int i = 0; i < 9; i++) chk_meta(i, 32'h0100_0040 + 32'(i));
    chk("t5_sent", {32'd0, sent_cnt}, 64'd15);
    meta_q.delete();
    rand_rdy = 1'b0;
    tx_ready = 1'b1;

    // Reset for one cycle in the middle of a packet
    send_beat(16'h0060, 16'h0600, 0, 1'b0, ones);
    send_beat(16'h0060, 16'h0600, 1, 1'b0, ones);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_pkt_tready", {63'd0, pkt_ready}, 64'd0);
    chk("mid_rst_status_tready", {63'd0, st_ready}, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rst_tx_tvalid", {63'd0, tx_valid}, 64'd0);
    chk("mid_rst_meta_tvalid", {63'd0, meta_valid}, 64'd0);
    chk("mid_rst_sent", {32'd0, sent_cnt}, 64'd0);
    chk("mid_rst_drop", {32'd0, drop_cnt}, 64'd0);
    chk("mid_rst_oversize", {32'd0, oversize_cnt}, 64'd0);
    chk("mid_rst_no_meta", 64'(meta_q.size()), 64'd0);
    @(posedge clk); #1;
    send_pkt(16'h0077, 16'h0700, 1, 64'h0000_0000_0000_0003);
    send_status(1'b0);
    exp_pkt(16'h0700, 1, 64'h0000_0000_0000_0003);
    wait_out();
    chk("t6_meta_n", 64'(meta_q.size()), 64'd1);
    chk_meta(0, 32'h0002_0077);
    chk("t6_sent", {32'd0, sent_cnt}, 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pkt_sender_mb.md
Name: pkt_sender_mb

Overview:
Multi-beat, parametrised TCP transmit sender. It accepts variable-length packets (1..MAX_PKT_BEATS beats) tagged with a session ID and stores each one whole in a payload FIFO. On the packet's last beat it issues one tx-metadata word (session, byte length). For each packet it consumes one tx-status word, then either streams the packet to the TCP stack or discards it if the status reports an error. It sits between the user kernel's result path and the TCP/IP stack's tx_metadata/tx_status/tx_data interfaces.

Parameters:
DATA_WIDTH, 512, data beat width in bits; multiple of 8.
KEEP_WIDTH, DATA_WIDTH/8, byte-enable width (derived, not overridden).
SESSION_WIDTH, 16, session ID width.
MAX_PKT_BEATS, 16, largest legal packet in beats; must be ≤ 2^PAYLOAD_ADDR_BITS, and MAX_PKT_BEATS*KEEP_WIDTH must be ≤ 65535.
PAYLOAD_ADDR_BITS, 5, log2 depth of the payload FIFO.
META_ADDR_BITS, 4, log2 depth of the metadata FIFO and the status FIFO.
STATUS_ERR_BIT, 62, error-flag bit in the tx-status word.

Ports:
clk  in  1  clock
rst_n  in  1  reset
s_axis_pkt_TDATA  in  DATA_WIDTH  payload beat
s_axis_pkt_TKEEP  in  KEEP_WIDTH  byte enables; contiguous from bit 0; all ones except on the last beat
s_axis_pkt_TLAST  in  1  last beat of packet
s_axis_pkt_TUSER  in  SESSION_WIDTH  session ID, sampled on the first beat only
s_axis_pkt_TVALID  in  1  / s_axis_pkt_TREADY  out  1  ingress handshake
s_axis_tx_status_TDATA  in  64  stack status word
s_axis_tx_status_TVALID  in  1  / s_axis_tx_status_TREADY  out  1
m_axis_tx_metadata_TDATA  out  32  {length[15:0], session zero-extended to 16 bits}
m_axis_tx_metadata_TVALID  out  1  / m_axis_tx_metadata_TREADY  in  1
m_axis_tx_data_TDATA  out  DATA_WIDTH
m_axis_tx_data_TKEEP  out  KEEP_WIDTH
m_axis_tx_data_TLAST  out  1
m_axis_tx_data_TVALID  out  1  / m_axis_tx_data_TREADY  in  1
sent_cnt  out  32  packets forwarded
drop_cnt  out  32  packets discarded on status error
oversize_cnt  out  32  packets truncated at MAX_PKT_BEATS

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is synchronous and active-low.
- While rst_n=0:
  - All TVALID outputs and all TREADY outputs are 0.
  - All counters and FIFOs are cleared; the FSM goes to IDLE.
- Reset mid-packet: partial packets are lost and no metadata is issued for them.
- Ingress, general:
  - s_axis_pkt_TREADY = payload FIFO not full AND (metadata FIFO not full OR the beat will not close a packet).
  - Beat counter beat_idx counts 0..MAX_PKT_BEATS-1.
  - Session is latched when beat_idx=0.
  - Each accepted beat pushes {last_eff, keep, data} into the payload FIFO.
- Ingress, packet close:
  - Length = beat_idx*KEEP_WIDTH + popcount(last keep), computed in 16 bits.
  - On the closing beat, metadata {length, session} is pushed in the same cycle.
- Ingress, oversize packets:
  - If beat_idx = MAX_PKT_BEATS-1 and TLAST=0, the beat is stored with last_eff=1, metadata is pushed, and oversize_cnt increments.
  - The ingress then enters DISCARD: it accepts beats with TREADY=1 and stores nothing until the input TLAST beat, then returns to normal.
- Egress FSM:
  - IDLE: wait for status FIFO valid. If the status error bit is set, pop status and go to DROP. Otherwise pop status and go to SEND. The status pop is a one-cycle handshake.
  - SEND: m_axis_tx_data_TVALID = payload FIFO valid; data, keep and last come from the FIFO head. Pop on VALID&READY. When a beat with last is popped: sent_cnt++ and go to IDLE.
  - DROP: pop one payload beat per cycle with TVALID=0. When last is popped: drop_cnt++ and go to IDLE.
- Ordering: status, metadata and packets are strictly in order, one status per packet. A status arriving before its packet's data is complete is legal because the FIFO depth guarantees completion.
- Output rules:
  - TLAST is only asserted together with TVALID.
  - TDATA, TKEEP and TLAST are held stable while TVALID=1 and TREADY=0.
- Counters: 32-bit, wrap modulo 2^32.
- Simultaneous events: an ingress push and an egress pop on the same FIFO in the same cycle are both honoured.
- Latency: the first egress beat follows the status pop by 1 cycle plus the FIFO read latency. There is no bubble between beats of one packet.

Decomposition:
- Package pkt_sender_pkg holds:
  - STATUS_ERR_BIT default;
  - metadata field offsets (LEN_LSB=16, LEN_W=16);
  - egress state enum (IDLE, SEND, DROP);
  - ingress mode enum (NORMAL, DISCARD).
- Reuse nukv_fifogen for the payload (DATA_WIDTH+KEEP_WIDTH+1 bits), metadata (32 bits) and status (1 bit) FIFOs.
- One natural new sub-module: keep_popcount (KEEP_WIDTH in → $clog2(KEEP_WIDTH)+1 out, combinational).

Test Plan:
- Single 1-beat packet: session 0x0005, keep=all ones, status OK → metadata 0x00400005; one output beat with TLAST=1; sent_cnt=1.
- 3-beat packet: last keep=0x0000_0000_0000_00FF, session 0x0012, status OK → metadata length 136 (0x0088); 3 beats forwarded unchanged.
- Status error on packet 2 of 3 (each 2 beats) → packets 1 and 3 forwarded, packet 2 never appears with TVALID=1; drop_cnt=1, sent_cnt=2.
- 20-beat input with MAX_PKT_BEATS=16 → 16 beats forwarded with TLAST on beat 16; metadata length 1024; oversize_cnt=1; next packet unaffected.
- m_axis_tx_data_TREADY random 30% plus metadata READY stalled for 50 cycles → no beat lost or duplicated, outputs stable under stall; ingress TREADY drops once the payload FIFO is full.
- rst_n=0 asserted for 1 cycle mid-packet → all VALIDs 0 the next cycle, counters 0; subsequent packet sent correctly.
